// File: rtl/out_mem_pkg.sv
// Shared types and frame geometry for the output frame buffer.
package out_mem_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} out_mem_state_t;

  localparam int FRAME_W   = 320;
  localparam int FRAME_H   = 240;
  localparam int FRAME_PIX = FRAME_W * FRAME_H;

endpackage

// File: rtl/out_mem_sat.sv
// Combinational conversion of a signed IN_W-bit result into a PIX_W-bit pixel
// (clamp to [0, 2^PIX_W-1] when SAT_MODE=1, plain truncation when SAT_MODE=0).
module out_mem_sat
  import out_mem_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int PIX_W    = 8,
  parameter int SAT_MODE = 1
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [PIX_W-1:0] pix
);

  generate
    if (SAT_MODE != 0) begin : g_sat
      // Non-negative values that set any bit above PIX_W exceed the pixel range.
      always_comb begin
        if (in_data[IN_W-1])
          pix = '0;
        else if (|in_data[IN_W-2:PIX_W])
          pix = '1;
        else
          pix = in_data[PIX_W-1:0];
      end
    end else begin : g_trunc
      assign pix = in_data[PIX_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/out_frame_buffer.sv
// Output frame store: converts accepted results to pixels, fills a DEPTH-entry memory
// sequentially and pulses frame_done per frame.
module out_frame_buffer
  import out_mem_pkg::*;
#(
  parameter int    IN_W      = 32,
  parameter int    PIX_W     = 8,
  parameter int    DEPTH     = FRAME_PIX,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter int    SAT_MODE  = 1,
  parameter string DUMP_FILE = "OutMemory.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              frame_done,
  output logic              busy,
  output logic [ADDR_W-1:0] pix_count,
  output logic [15:0]       frame_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid
);

  out_mem_state_t   state;
  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] pix;
  logic             accept;
  logic             last_pix;

  out_mem_sat #(
    .IN_W    (IN_W),
    .PIX_W   (PIX_W),
    .SAT_MODE(SAT_MODE)
  ) u_sat (
    .in_data(in_data),
    .pix    (pix)
  );

  // A start in FILL restarts the frame, so the beat offered alongside it is refused.
  assign in_ready = (state == FILL) && !start;
  assign accept   = in_valid && in_ready;
  assign last_pix = (32'(pix_count) == DEPTH - 1);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      pix_count   <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FILL;
            busy      <= 1'b1;
            pix_count <= '0;
          end
        end
        FILL: begin
          if (start) begin
            pix_count <= '0;
          end else if (accept) begin
            if (last_pix) begin
              state       <= DONE;
              busy        <= 1'b0;
              pix_count   <= '0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              pix_count <= pix_count + ADDR_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the pixel array has no reset; clearing it would defeat RAM inference
  // and the frame contents are fully rewritten before they are meaningful.
  always_ff @(posedge clk) begin
    if (accept)
      mem[pix_count] <= pix;
  end

  // Read sees the array before this edge's write, giving old data on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule
